// File: rtl/fetch_inst_buffer_if.sv
// Fetch/backend handshake bundle for fetch_inst_buffer.
// Perf-counter outputs exist only when FETCH_BUF_PERF_EN is defined.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

interface fetch_inst_buffer_if #(
  parameter int DEPTH   = 16,
  parameter int IN_W    = `FETCH_WIDTH,
  parameter int OUT_W   = `FETCH_WIDTH,
  parameter int ENTRY_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [IN_W-1:0]               i_enq_vld;
  logic [IN_W-1:0][ENTRY_W-1:0]  i_enq_inst;
  logic                          o_enq_rdy;
  logic [OUT_W-1:0]              o_deq_vld;
  logic [OUT_W-1:0][ENTRY_W-1:0] o_deq_inst;
  logic                          i_backend_stall;
  logic                          i_squash_vld;
  logic [CNT_W-1:0]              o_count;
`ifdef FETCH_BUF_PERF_EN
  logic [31:0]                   o_perf_full_cycles;
  logic [31:0]                   o_perf_starve_cycles;

  modport master (
    output i_enq_vld, i_enq_inst, i_backend_stall, i_squash_vld,
    input  o_enq_rdy, o_deq_vld, o_deq_inst, o_count,
           o_perf_full_cycles, o_perf_starve_cycles
  );
  modport slave (
    input  i_enq_vld, i_enq_inst, i_backend_stall, i_squash_vld,
    output o_enq_rdy, o_deq_vld, o_deq_inst, o_count,
           o_perf_full_cycles, o_perf_starve_cycles
  );
`else
  modport master (
    output i_enq_vld, i_enq_inst, i_backend_stall, i_squash_vld,
    input  o_enq_rdy, o_deq_vld, o_deq_inst, o_count
  );
  modport slave (
    input  i_enq_vld, i_enq_inst, i_backend_stall, i_squash_vld,
    output o_enq_rdy, o_deq_vld, o_deq_inst, o_count
  );
`endif
endinterface

// File: rtl/fetch_inst_buffer.sv
// Compacting circular instruction queue between fetch and the backend.
// Define FETCH_BUF_PERF_EN to add saturating full/starve perf counters.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

module fetch_inst_buffer_chk #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int CNT_W = 5
) (
  input logic             clk,
  input logic             rst,
  input logic [PTR_W-1:0] rptr,
  input logic [PTR_W-1:0] wptr,
  input logic [CNT_W-1:0] count
);
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count <= CNT_W'(DEPTH));
  a_ptr_count: assert property (@(posedge clk) disable iff (rst)
    PTR_W'(wptr - rptr) == count[PTR_W-1:0]);
endmodule

module fetch_inst_buffer #(
  parameter int DEPTH   = 16,
  parameter int IN_W    = `FETCH_WIDTH,
  parameter int OUT_W   = `FETCH_WIDTH,
  parameter int ENTRY_W = 32
) (
  input logic                clk,
  input logic                rst,
  fetch_inst_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] IN_W_C  = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] OUT_W_C = CNT_W'(OUT_W);

  logic [ENTRY_W-1:0]          mem_q [DEPTH];
  logic [ENTRY_W-1:0]          mem_d [DEPTH];
  logic [PTR_W-1:0]            rptr_q, rptr_d;
  logic [PTR_W-1:0]            wptr_q, wptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        enq_rdy_s;
  logic                        enq_fire_s;
  logic                        deq_fire_s;
  logic [CNT_W-1:0]            nenq_s;
  logic [CNT_W-1:0]            navail_s;
  logic [CNT_W-1:0]            ndeq_s;
  logic [CNT_W-1:0]            enq_add_s;
  logic [IN_W-1:0][PTR_W-1:0]  lane_off_s;

  // Readiness and dequeue width come from registered occupancy only.
  always_comb begin
    enq_rdy_s = (DEPTH_C - count_q) >= IN_W_C;
    if (count_q >= OUT_W_C) begin
      navail_s = OUT_W_C;
    end else begin
      navail_s = count_q;
    end
  end

  // Compaction: each set lane lands at wptr plus the number of set lanes below it.
  always_comb begin
    nenq_s = CNT_W'(0);
    for (int i = 0; i < IN_W; i++) begin
      lane_off_s[i] = nenq_s[PTR_W-1:0];
      nenq_s = nenq_s + CNT_W'(bus.i_enq_vld[i]);
    end
  end

  // Fire conditions; squash overrides both enqueue and dequeue.
  always_comb begin
    enq_fire_s = enq_rdy_s && !bus.i_squash_vld && (|bus.i_enq_vld);
    deq_fire_s = !bus.i_backend_stall && !bus.i_squash_vld;
    if (deq_fire_s) begin
      ndeq_s = navail_s;
    end else begin
      ndeq_s = CNT_W'(0);
    end
    if (enq_fire_s) begin
      enq_add_s = nenq_s;
    end else begin
      enq_add_s = CNT_W'(0);
    end
  end

  // Storage write: scatter the compacted lanes into the circular array.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      mem_d[j] = mem_q[j];
      for (int i = 0; i < IN_W; i++) begin
        mem_d[j] = (enq_fire_s && bus.i_enq_vld[i] &&
                    (PTR_W'(wptr_q + lane_off_s[i]) == PTR_W'(j)))
                   ? bus.i_enq_inst[i] : mem_d[j];
      end
    end
  end

  // Pointer and occupancy next-state.
  always_comb begin
    if (bus.i_squash_vld) begin
      rptr_d  = PTR_W'(0);
      wptr_d  = PTR_W'(0);
      count_d = CNT_W'(0);
    end else begin
      rptr_d  = rptr_q + ndeq_s[PTR_W-1:0];
      wptr_d  = wptr_q + enq_add_s[PTR_W-1:0];
      count_d = count_q + enq_add_s - ndeq_s;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= PTR_W'(0);
      wptr_q  <= PTR_W'(0);
      count_q <= CNT_W'(0);
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset; contents are qualified by count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Dequeue view; squash hides every lane in the squash cycle.
  always_comb begin
    for (int i = 0; i < OUT_W; i++) begin
      bus.o_deq_vld[i]  = (CNT_W'(i) < navail_s) && !bus.i_squash_vld;
      bus.o_deq_inst[i] = mem_q[PTR_W'(rptr_q + PTR_W'(i))];
    end
  end

  assign bus.o_enq_rdy = enq_rdy_s;
  assign bus.o_count   = count_q;

`ifdef FETCH_BUF_PERF_EN
  logic [31:0] perf_full_q, perf_full_d;
  logic [31:0] perf_starve_q, perf_starve_d;

  // Saturating event counters; squash intentionally leaves them intact.
  always_comb begin
    if (!enq_rdy_s && (|bus.i_enq_vld) && (perf_full_q != 32'hFFFF_FFFF)) begin
      perf_full_d = perf_full_q + 32'd1;
    end else begin
      perf_full_d = perf_full_q;
    end
    if ((count_q == CNT_W'(0)) && !bus.i_backend_stall &&
        (perf_starve_q != 32'hFFFF_FFFF)) begin
      perf_starve_d = perf_starve_q + 32'd1;
    end else begin
      perf_starve_d = perf_starve_q;
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_q   <= 32'd0;
      perf_starve_q <= 32'd0;
    end else begin
      perf_full_q   <= perf_full_d;
      perf_starve_q <= perf_starve_d;
    end
  end

  assign bus.o_perf_full_cycles   = perf_full_q;
  assign bus.o_perf_starve_cycles = perf_starve_q;
`endif

  fetch_inst_buffer_chk #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .rptr  (rptr_q),
    .wptr  (wptr_q),
    .count (count_q)
  );
endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Self-checking bench for fetch_inst_buffer: directed table, corner sequences, random vs queue model.
module tb_fetch_inst_buffer;
  localparam int DEPTH = 16;
  localparam int IN_W  = 4;
  localparam int OUT_W = 4;
  localparam int EW    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_inst_buffer_if #(.DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .ENTRY_W(EW)) bus ();
  fetch_inst_buffer #(.DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .ENTRY_W(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  logic [EW-1:0] mq[$];
  logic cur_rst, cur_stall, cur_squash;
  logic [3:0] cur_vld;
  logic [3:0][EW-1:0] cur_inst;
`ifdef FETCH_BUF_PERF_EN
  logic [31:0] m_full = 32'd0;
  logic [31:0] m_starve = 32'd0;
  logic [31:0] base_full, base_starve;
`endif

  typedef struct {
    logic [3:0]    vld;
    logic          stall;
    logic          squash;
    logic [3:0]    exp_vld;
    logic [4:0]    exp_count;
    logic          exp_rdy;
    logic [EW-1:0] exp_l0;
    logic [EW-1:0] exp_l1;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0][EW-1:0] mk(input logic [EW-1:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic apply(input logic r, input logic [3:0] vld, input logic [3:0][EW-1:0] inst,
                       input logic stall, input logic squash);
    cur_rst = r; cur_vld = vld; cur_inst = inst; cur_stall = stall; cur_squash = squash;
    rst = r;
    bus.i_enq_vld = vld;
    bus.i_enq_inst = inst;
    bus.i_backend_stall = stall;
    bus.i_squash_vld = squash;
  endtask

  // Compare every output with the queue model at the falling edge.
  task automatic sample();
    int navail;
    logic [3:0] ev;
    logic rdy;
    @(negedge clk);
    navail = (mq.size() < OUT_W) ? mq.size() : OUT_W;
    rdy = ((DEPTH - mq.size()) >= IN_W);
    ev = cur_squash ? 4'b0000 : 4'((1 << navail) - 1);
    if (chk_en) begin
      chk("enq_rdy", 32'(bus.o_enq_rdy), 32'(rdy));
      chk("count", 32'(bus.o_count), 32'(mq.size()));
      chk("deq_vld", 32'(bus.o_deq_vld), 32'(ev));
      for (int i = 0; i < OUT_W; i++)
        if (ev[i]) chk("deq_inst", bus.o_deq_inst[i], mq[i]);
`ifdef FETCH_BUF_PERF_EN
      chk("perf_full", bus.o_perf_full_cycles, m_full);
      chk("perf_starve", bus.o_perf_starve_cycles, m_starve);
`endif
    end
  endtask

  // Advance the model across the rising edge.
  task automatic commit();
    int navail;
    logic rdy;
    @(posedge clk);
    navail = (mq.size() < OUT_W) ? mq.size() : OUT_W;
    rdy = ((DEPTH - mq.size()) >= IN_W);
    if (cur_rst) begin
      mq.delete();
`ifdef FETCH_BUF_PERF_EN
      m_full = 32'd0;
      m_starve = 32'd0;
`endif
    end else begin
`ifdef FETCH_BUF_PERF_EN
      if (!rdy && (cur_vld != 4'b0000) && m_full != 32'hFFFF_FFFF) m_full = m_full + 32'd1;
      if (mq.size() == 0 && !cur_stall && m_starve != 32'hFFFF_FFFF) m_starve = m_starve + 32'd1;
`endif
      if (cur_squash) begin
        mq.delete();
      end else begin
        if (!cur_stall) repeat (navail) void'(mq.pop_front());
        if (rdy) for (int i = 0; i < IN_W; i++) if (cur_vld[i]) mq.push_back(cur_inst[i]);
      end
    end
    #1;
  endtask

  task automatic cycle(input logic [3:0] vld, input logic [3:0][EW-1:0] inst,
                       input logic stall, input logic squash);
    apply(1'b0, vld, inst, stall, squash);
    sample();
    commit();
  endtask

  initial begin
    logic [3:0][EW-1:0] rinst;
    // reset
    apply(1'b1, 4'b0000, mk(32'd0), 1'b0, 1'b0);
    sample(); commit();
    sample(); commit();
    chk_en = 1'b1;

    // Full group then sparse group; row 0 also checks the post-reset state.
    tbl[0] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 5'd0, 1'b1, 32'h0, 32'h0};
    tbl[1] = '{4'b0000, 1'b0, 1'b0, 4'b1111, 5'd4, 1'b1, 32'hA000_0000, 32'hA000_0001};
    tbl[2] = '{4'b1010, 1'b0, 1'b0, 4'b0000, 5'd0, 1'b1, 32'h0, 32'h0};
    tbl[3] = '{4'b0000, 1'b0, 1'b0, 4'b0011, 5'd2, 1'b1, 32'hA000_0201, 32'hA000_0203};
    tbl[4] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 5'd0, 1'b1, 32'h0, 32'h0};
    for (int r = 0; r < 5; r++) begin
      apply(1'b0, tbl[r].vld, mk(32'hA000_0000 + 32'(r) * 32'd256), tbl[r].stall, tbl[r].squash);
      sample();
      chk("tbl_deq_vld", 32'(bus.o_deq_vld), 32'(tbl[r].exp_vld));
      chk("tbl_count", 32'(bus.o_count), 32'(tbl[r].exp_count));
      chk("tbl_enq_rdy", 32'(bus.o_enq_rdy), 32'(tbl[r].exp_rdy));
      if (tbl[r].exp_vld[0]) chk("tbl_lane0", bus.o_deq_inst[0], tbl[r].exp_l0);
      if (tbl[r].exp_vld[1]) chk("tbl_lane1", bus.o_deq_inst[1], tbl[r].exp_l1);
      commit();
    end

    // Fill to full under stall, 5th group ignored, then drain in order.
    for (int g = 0; g < 4; g++) cycle(4'b1111, mk(32'hB000_0000 + 32'(g) * 32'd16), 1'b1, 1'b0);
    apply(1'b0, 4'b1111, mk(32'hBEEF_0000), 1'b1, 1'b0);
    sample();
    chk("full_count", 32'(bus.o_count), 32'd16);
    chk("full_rdy", 32'(bus.o_enq_rdy), 32'd0);
    commit();
    apply(1'b0, 4'b0000, mk(32'd0), 1'b0, 1'b0);
    sample();
    chk("drain_first", bus.o_deq_inst[0], 32'hB000_0000);
    commit();
    for (int g = 0; g < 4; g++) cycle(4'b0000, mk(32'd0), 1'b0, 1'b0);

    // Wrap: zero pointers, advance both to 14, then straddle the end.
    cycle(4'b0000, mk(32'd0), 1'b0, 1'b1);
    for (int g = 0; g < 3; g++) cycle(4'b1111, mk(32'h9000_0000 + 32'(g) * 32'd16), 1'b1, 1'b0);
    cycle(4'b0011, mk(32'h9000_0030), 1'b1, 1'b0);
    for (int g = 0; g < 4; g++) cycle(4'b0000, mk(32'd0), 1'b0, 1'b0);
    cycle(4'b1111, mk(32'hC000_0000), 1'b0, 1'b0);
    apply(1'b0, 4'b0000, mk(32'd0), 1'b0, 1'b0);
    sample();
    chk("wrap_vld", 32'(bus.o_deq_vld), 32'hF);
    for (int i = 0; i < 4; i++) chk("wrap_lane", bus.o_deq_inst[i], 32'hC000_0000 + 32'(i));
    commit();

    // Squash with count=10 and a same-cycle enqueue.
    cycle(4'b1111, mk(32'hD100_0000), 1'b1, 1'b0);
    cycle(4'b1111, mk(32'hD200_0000), 1'b1, 1'b0);
    cycle(4'b0011, mk(32'hD300_0000), 1'b1, 1'b0);
    apply(1'b0, 4'b1111, mk(32'hDEAD_0000), 1'b0, 1'b1);
    sample();
    chk("sq_count_pre", 32'(bus.o_count), 32'd10);
    chk("sq_deq_vld", 32'(bus.o_deq_vld), 32'd0);
    commit();
    apply(1'b0, 4'b0000, mk(32'd0), 1'b0, 1'b0);
    sample();
    chk("sq_count_post", 32'(bus.o_count), 32'd0);
    chk("sq_deq_vld_post", 32'(bus.o_deq_vld), 32'd0);
    chk("sq_rdy_post", 32'(bus.o_enq_rdy), 32'd1);
    commit();
    cycle(4'b0000, mk(32'd0), 1'b0, 1'b0);

`ifdef FETCH_BUF_PERF_EN
    for (int g = 0; g < 4; g++) cycle(4'b1111, mk(32'hE000_0000 + 32'(g) * 32'd16), 1'b1, 1'b0);
    base_full = m_full;
    for (int g = 0; g < 7; g++) cycle(4'b1111, mk(32'hEE00_0000), 1'b1, 1'b0);
    apply(1'b0, 4'b0000, mk(32'd0), 1'b1, 1'b1);
    sample();
    chk("perf_full_7", bus.o_perf_full_cycles, base_full + 32'd7);
    commit();
    base_starve = m_starve;
    for (int g = 0; g < 3; g++) cycle(4'b0000, mk(32'd0), 1'b0, 1'b0);
    apply(1'b0, 4'b0000, mk(32'd0), 1'b1, 1'b0);
    sample();
    chk("perf_starve_3", bus.o_perf_starve_cycles, base_starve + 32'd3);
    chk("perf_full_kept", bus.o_perf_full_cycles, base_full + 32'd7);
    commit();
`endif

    // Random traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) rinst[i] = $urandom;
      apply(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)), rinst,
            ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
      sample();
      commit();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
